// File: rtl/flash_arb_pkg.sv
// Shared types and default widths for the two-client flash read arbiter.
package flash_arb_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int FLASH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

    typedef logic client_idx_t;

endpackage

// File: rtl/flash_arb_rr2.sv
// Two-way combinational grant picker: round-robin by default,
// fixed priority to client 0 when FLASH_ARB_PRIORITY_EN is defined.
module flash_arb_rr2
    import flash_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  client_idx_t last_grant,
    output client_idx_t winner
);

`ifdef FLASH_ARB_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01: winner = 1'b0;
            2'b10: winner = 1'b1;
`ifdef FLASH_ARB_PRIORITY_EN
            2'b11: winner = 1'b0;
`else
            2'b11: winner = ~last_grant;
`endif
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read port between two clients, one read in flight,
// with response timeout. Define FLASH_ARB_PRIORITY_EN for fixed priority to client 0.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W      = FLASH_ADDR_W,
    parameter int DATA_W      = FLASH_DATA_W,
    parameter int TIMEOUT_CYC = 255
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_read,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic [3:0]        c0_byteenable,
    output logic              c0_waitrequest,
    output logic [DATA_W-1:0] c0_readdata,
    output logic              c0_readdatavalid,
    output logic              c0_timeout,
    input  logic              c1_read,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic [3:0]        c1_byteenable,
    output logic              c1_waitrequest,
    output logic [DATA_W-1:0] c1_readdata,
    output logic              c1_readdatavalid,
    output logic              c1_timeout,
    output logic              flsh_read,
    output logic [ADDR_W-1:0] flsh_address,
    output logic [3:0]        flsh_byteenable,
    input  logic              flsh_waitrequest,
    input  logic [DATA_W-1:0] flsh_readdata,
    input  logic              flsh_readdatavalid,
    output logic              owner,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    // Counter is cleared on acceptance and reads k-1 in cycle A+k
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t       state;
    client_idx_t      owner_q;
    client_idx_t      last_grant;
    client_idx_t      winner;
    logic [CNT_W-1:0] cnt;
    logic             resp_done;
    logic             resp_to;

    flash_arb_rr2 u_rr2 (
        .req        ({c1_read, c0_read}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign resp_done = (state == WAIT_DATA) && flsh_readdatavalid;
    assign resp_to   = (state == WAIT_DATA) && !flsh_readdatavalid && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            owner_q         <= 1'b0;
            last_grant      <= 1'b1;
            cnt             <= '0;
            flsh_address    <= '0;
            flsh_byteenable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c0_read || c1_read) begin
                        owner_q         <= winner;
                        flsh_address    <= winner ? c1_address : c0_address;
                        flsh_byteenable <= winner ? c1_byteenable : c0_byteenable;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!flsh_waitrequest) begin
                        cnt   <= '0;
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (resp_done || resp_to) begin
                        last_grant <= owner_q;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flsh_read        = (state == ISSUE);
    assign busy             = (state != IDLE);
    assign owner            = owner_q;

    assign c0_waitrequest   = !((state == ISSUE) && !owner_q) || flsh_waitrequest;
    assign c1_waitrequest   = !((state == ISSUE) &&  owner_q) || flsh_waitrequest;

    assign c0_readdata      = flsh_readdata;
    assign c1_readdata      = flsh_readdata;
    assign c0_readdatavalid = resp_done && !owner_q;
    assign c1_readdatavalid = resp_done &&  owner_q;
    assign c0_timeout       = resp_to && !owner_q;
    assign c1_timeout       = resp_to &&  owner_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Randomized scoreboard bench for flash_read_arbiter; the bench itself plays
// both clients and the flash slave, predicting grants and responses per transaction.
module tb_flash_read_arbiter;
    import flash_arb_pkg::*;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c0_read = 1'b0, c1_read = 1'b0;
    logic [AW-1:0] c0_address = '0, c1_address = '0;
    logic [3:0]    c0_byteenable = '0, c1_byteenable = '0;
    logic          c0_waitrequest, c1_waitrequest;
    logic [DW-1:0] c0_readdata, c1_readdata;
    logic          c0_readdatavalid, c1_readdatavalid;
    logic          c0_timeout, c1_timeout;
    logic          flsh_read;
    logic [AW-1:0] flsh_address;
    logic [3:0]    flsh_byteenable;
    logic          flsh_waitrequest = 1'b1;
    logic [DW-1:0] flsh_readdata = '0;
    logic          flsh_readdatavalid = 1'b0;
    logic          owner, busy;

    flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .c0_read(c0_read), .c0_address(c0_address), .c0_byteenable(c0_byteenable),
        .c0_waitrequest(c0_waitrequest), .c0_readdata(c0_readdata),
        .c0_readdatavalid(c0_readdatavalid), .c0_timeout(c0_timeout),
        .c1_read(c1_read), .c1_address(c1_address), .c1_byteenable(c1_byteenable),
        .c1_waitrequest(c1_waitrequest), .c1_readdata(c1_readdata),
        .c1_readdatavalid(c1_readdatavalid), .c1_timeout(c1_timeout),
        .flsh_read(flsh_read), .flsh_address(flsh_address), .flsh_byteenable(flsh_byteenable),
        .flsh_waitrequest(flsh_waitrequest), .flsh_readdata(flsh_readdata),
        .flsh_readdatavalid(flsh_readdatavalid),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int          client;
        bit          to;
        logic [31:0] data;
        int unsigned cycle;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Client, flash-slave and arbitration model state
    bit          pend[2];
    logic [AW-1:0] addr[2];
    logic [3:0]  be[2];
    logic [1:0]  req;
    bit          allow_new = 1'b1;
    bit          issuing = 1'b0, in_flight = 1'b0;
    int          g = 0, last_g = 1, m_owner = 0;
    int unsigned acc = 0, resp_cyc = 0, late_cyc = 0;
    logic [31:0] resp_data = '0;
    logic        nx_wr = 1'b1, nx_rdv = 1'b0;
    logic [31:0] nx_data = '0;

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef FLASH_ARB_PRIORITY_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    task automatic new_req(input int k);
        pend[k] = 1'b1;
        addr[k] = AW'($urandom);
        be[k]   = 4'($urandom);
    endtask

    task automatic observe();
        bit idle_now;
        int r;
        idle_now = !issuing && !in_flight;
        chk("busy", busy, !idle_now);
        chk("flsh_read", flsh_read, issuing);
        chk("owner", owner, m_owner);
        if (issuing) begin
            chk("flsh_address", flsh_address, addr[g]);
            chk("flsh_byteenable", flsh_byteenable, be[g]);
        end
        chk("c0_waitrequest", c0_waitrequest, (issuing && g == 0) ? flsh_waitrequest : 1'b1);
        chk("c1_waitrequest", c1_waitrequest, (issuing && g == 1) ? flsh_waitrequest : 1'b1);

        if (in_flight && (cyc == resp_cyc || cyc == acc + TO)) begin
            in_flight = 1'b0;
            last_g    = g;
        end
        if (issuing && !flsh_waitrequest) begin
            issuing   = 1'b0;
            in_flight = 1'b1;
            acc       = cyc;
            pend[g]   = 1'b0;
            r = $urandom_range(1, TO + 2);
            if (r <= TO) begin
                resp_cyc  = acc + r;
                resp_data = $urandom;
                q.push_back('{client: g, to: 1'b0, data: resp_data, cycle: resp_cyc});
            end else begin
                resp_cyc = 0;
                late_cyc = acc + TO + $urandom_range(1, 4);
                q.push_back('{client: g, to: 1'b1, data: '0, cycle: acc + TO});
            end
        end
        if (idle_now && req != 2'b00) begin
            g       = pick(req, last_g);
            m_owner = g;
            issuing = 1'b1;
        end

        for (int k = 0; k < 2; k++)
            if (allow_new && !pend[k] && $urandom_range(0, 2) == 0) new_req(k);
        nx_wr   = 1'($urandom_range(0, 1));
        nx_data = $urandom;
        nx_rdv  = 1'b0;
        if (in_flight && cyc + 1 == resp_cyc) begin
            nx_rdv  = 1'b1;
            nx_data = resp_data;
        end else if (!in_flight && (cyc + 1 == late_cyc || $urandom_range(0, 7) == 0)) begin
            nx_rdv = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c0_read = pend[0]; c0_address = addr[0]; c0_byteenable = be[0];
        c1_read = pend[1]; c1_address = addr[1]; c1_byteenable = be[1];
        flsh_waitrequest   = nx_wr;
        flsh_readdatavalid = nx_rdv;
        flsh_readdata      = nx_data;
        req = {pend[1], pend[0]};
        @(negedge clk);
        observe();
    endtask

    task automatic check_reset_values();
        chk("rst_busy", busy, 1'b0);
        chk("rst_flsh_read", flsh_read, 1'b0);
        chk("rst_flsh_address", flsh_address, '0);
        chk("rst_flsh_byteenable", flsh_byteenable, '0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_waitrequest", {c1_waitrequest, c0_waitrequest}, 2'b11);
        chk("rst_valid_timeout", {c1_timeout, c0_timeout, c1_readdatavalid, c0_readdatavalid}, 4'b0000);
    endtask

    task automatic do_reset();
        int n = 0;
        while (!in_flight && n < 200) begin
            step();
            n++;
        end
        chk("reach_wait_data", in_flight, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0_read = 1'b0; c1_read = 1'b0;
        flsh_waitrequest   = 1'b1;
        flsh_readdatavalid = 1'b1;
        flsh_readdata      = 32'h1234_5678;
        @(negedge clk);
        check_reset_values();
        issuing = 1'b0; in_flight = 1'b0;
        last_g = 1; m_owner = 0; g = 0;
        late_cyc = 0; resp_cyc = 0;
        q.delete();
        new_req(0);
        new_req(1);
        nx_rdv = 1'b1; nx_wr = 1'b1; nx_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        rst = 1'b1;
        flsh_readdatavalid = 1'b0;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [3:0]  bits, eb;
        forever begin
            @(negedge clk);
            bits = {c1_timeout, c0_timeout, c1_readdatavalid, c0_readdatavalid};
            if (rst && bits != 4'b0000) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", bits, 4'b0000);
                end else begin
                    e  = q.pop_front();
                    eb = e.to ? (e.client == 1 ? 4'b1000 : 4'b0100)
                              : (e.client == 1 ? 4'b0010 : 4'b0001);
                    chk("resp_kind", bits, eb);
                    chk("resp_cycle", cyc, e.cycle);
                    if (!e.to)
                        chk("resp_data", e.client == 1 ? c1_readdata : c0_readdata, e.data);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        pend[0] = 1'b0; pend[1] = 1'b0;
        addr[0] = '0; addr[1] = '0; be[0] = '0; be[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b1;
        new_req(0);
        new_req(1);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step();
        end
        allow_new = 1'b0;
        n = 0;
        while ((pend[0] || pend[1] || issuing || in_flight || q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        repeat (2) step();
        chk("drain_outstanding", q.size(), 0);
        chk("drain_idle", busy, 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
